// File: rtl/axi4_lite_apb_bridge.sv
`default_nettype none
// +------------------------------------------------------------------------------+
// | axi4_lite_apb_bridge : AXI4-Lite slave to multi-slave APB master bridge       |
// | Revision 1.0                                                                  |
// +------------------------------------------------------------------------------+
module axi4_lite_apb_bridge #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int NUM_SLAVES     = 4,
    parameter int SLAVE_ADDR_LSB = 12,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                             ACLK,
    input  logic                             ARESETn,
    input  logic [ADDR_WIDTH-1:0]            AWADDR,
    input  logic                             AWVALID,
    output logic                             AWREADY,
    input  logic [DATA_WIDTH-1:0]            WDATA,
    input  logic [DATA_WIDTH/8-1:0]          WSTRB,
    input  logic                             WVALID,
    output logic                             WREADY,
    output logic [1:0]                       BRESP,
    output logic                             BVALID,
    input  logic                             BREADY,
    input  logic [ADDR_WIDTH-1:0]            ARADDR,
    input  logic                             ARVALID,
    output logic                             ARREADY,
    output logic [DATA_WIDTH-1:0]            RDATA,
    output logic [1:0]                       RRESP,
    output logic                             RVALID,
    input  logic                             RREADY,
    output logic [ADDR_WIDTH-1:0]            PADDR,
    output logic                             PWRITE,
    output logic [DATA_WIDTH-1:0]            PWDATA,
    output logic [DATA_WIDTH/8-1:0]          PSTRB,
    output logic [NUM_SLAVES-1:0]            PSEL,
    output logic                             PENABLE,
    input  logic [NUM_SLAVES*DATA_WIDTH-1:0] PRDATA,
    input  logic [NUM_SLAVES-1:0]            PREADY,
    input  logic [NUM_SLAVES-1:0]            PSLVERR
);

    localparam int STRB_W = DATA_WIDTH / 8;
    localparam int SEL_W  = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
    localparam int TO_W   = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    localparam logic [SEL_W:0] NSLV      = (SEL_W + 1)'(NUM_SLAVES);
    localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(TIMEOUT_CYCLES);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] SETUP  = 2'd1;
    localparam logic [1:0] ACCESS = 2'd2;
    localparam logic [1:0] RESP   = 2'd3;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    logic [1:0]            state_q,   state_d;
    logic                  last_wr_q, last_wr_d;
    logic                  write_q,   write_d;
    logic [SEL_W-1:0]      idx_q,     idx_d;
    logic [TO_W-1:0]       tcnt_q,    tcnt_d;
    logic [ADDR_WIDTH-1:0] paddr_q,   paddr_d;
    logic                  pwrite_q,  pwrite_d;
    logic [DATA_WIDTH-1:0] pwdata_q,  pwdata_d;
    logic [STRB_W-1:0]     pstrb_q,   pstrb_d;
    logic [NUM_SLAVES-1:0] psel_q,    psel_d;
    logic                  penable_q, penable_d;
    logic                  bvalid_q,  bvalid_d;
    logic                  rvalid_q,  rvalid_d;
    logic [1:0]            bresp_q,   bresp_d;
    logic [1:0]            rresp_q,   rresp_d;
    logic [DATA_WIDTH-1:0] rdata_q,   rdata_d;

    logic                  wr_req, rd_req, grant_wr, grant_rd, dec_ok;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [SEL_W-1:0]      req_idx;
    logic                  sel_ready, sel_err;
    logic [DATA_WIDTH-1:0] sel_rdata;

    // Fair arbitration: on contention the direction not served last wins.
    assign wr_req   = AWVALID & WVALID;
    assign rd_req   = ARVALID;
    assign grant_wr = (state_q == IDLE) & wr_req & (~rd_req | ~last_wr_q);
    assign grant_rd = (state_q == IDLE) & rd_req & ~grant_wr;

    assign AWREADY = grant_wr & ARESETn;
    assign WREADY  = grant_wr & ARESETn;
    assign ARREADY = grant_rd & ARESETn;

    assign req_addr = grant_wr ? AWADDR : ARADDR;
    assign req_idx  = req_addr[SLAVE_ADDR_LSB +: SEL_W];
    assign dec_ok   = ({1'b0, req_idx} < NSLV);

    // Only the selected slave's return signals are observed.
    always_comb begin
        sel_ready = 1'b0;
        sel_err   = 1'b0;
        sel_rdata = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (idx_q == SEL_W'(i)) begin
                sel_ready = PREADY[i];
                sel_err   = PSLVERR[i];
                sel_rdata = PRDATA[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        last_wr_d = last_wr_q;
        write_d   = write_q;
        idx_d     = idx_q;
        tcnt_d    = tcnt_q;
        paddr_d   = paddr_q;
        pwrite_d  = pwrite_q;
        pwdata_d  = pwdata_q;
        pstrb_d   = pstrb_q;
        psel_d    = psel_q;
        penable_d = penable_q;
        bvalid_d  = bvalid_q;
        rvalid_d  = rvalid_q;
        bresp_d   = bresp_q;
        rresp_d   = rresp_q;
        rdata_d   = rdata_q;

        case (state_q)
            IDLE: begin
                if (grant_wr | grant_rd) begin
                    last_wr_d = grant_wr;
                    write_d   = grant_wr;
                    if (dec_ok) begin
                        idx_d    = req_idx;
                        paddr_d  = req_addr;
                        pwrite_d = grant_wr;
                        pwdata_d = grant_wr ? WDATA : '0;
                        pstrb_d  = grant_wr ? WSTRB : '0;
                        psel_d   = NUM_SLAVES'(1) << req_idx;
                        tcnt_d   = '0;
                        state_d  = SETUP;
                    end else begin
                        state_d = RESP;
                        if (grant_wr) begin
                            bvalid_d = 1'b1;
                            bresp_d  = RESP_DECERR;
                        end else begin
                            rvalid_d = 1'b1;
                            rresp_d  = RESP_DECERR;
                            rdata_d  = '0;
                        end
                    end
                end
            end
            SETUP: begin
                penable_d = 1'b1;
                state_d   = ACCESS;
            end
            ACCESS: begin
                if (sel_ready) begin
                    psel_d    = '0;
                    penable_d = 1'b0;
                    state_d   = RESP;
                    if (write_q) begin
                        bvalid_d = 1'b1;
                        bresp_d  = sel_err ? RESP_SLVERR : RESP_OKAY;
                    end else begin
                        rvalid_d = 1'b1;
                        rresp_d  = sel_err ? RESP_SLVERR : RESP_OKAY;
                        rdata_d  = sel_rdata;
                    end
                end else if ((TIMEOUT_CYCLES != 0) && (tcnt_q == TO_LIMIT)) begin
                    psel_d    = '0;
                    penable_d = 1'b0;
                    state_d   = RESP;
                    if (write_q) begin
                        bvalid_d = 1'b1;
                        bresp_d  = RESP_SLVERR;
                    end else begin
                        rvalid_d = 1'b1;
                        rresp_d  = RESP_SLVERR;
                        rdata_d  = '0;
                    end
                end else begin
                    tcnt_d = tcnt_q + TO_W'(1);
                end
            end
            RESP: begin
                if ((bvalid_q & BREADY) | (rvalid_q & RREADY)) begin
                    bvalid_d = 1'b0;
                    rvalid_d = 1'b0;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state_q   <= IDLE;
            last_wr_q <= 1'b0;
            write_q   <= 1'b0;
            idx_q     <= '0;
            tcnt_q    <= '0;
            paddr_q   <= '0;
            pwrite_q  <= 1'b0;
            pwdata_q  <= '0;
            pstrb_q   <= '0;
            psel_q    <= '0;
            penable_q <= 1'b0;
            bvalid_q  <= 1'b0;
            rvalid_q  <= 1'b0;
            bresp_q   <= 2'b00;
            rresp_q   <= 2'b00;
            rdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            last_wr_q <= last_wr_d;
            write_q   <= write_d;
            idx_q     <= idx_d;
            tcnt_q    <= tcnt_d;
            paddr_q   <= paddr_d;
            pwrite_q  <= pwrite_d;
            pwdata_q  <= pwdata_d;
            pstrb_q   <= pstrb_d;
            psel_q    <= psel_d;
            penable_q <= penable_d;
            bvalid_q  <= bvalid_d;
            rvalid_q  <= rvalid_d;
            bresp_q   <= bresp_d;
            rresp_q   <= rresp_d;
            rdata_q   <= rdata_d;
        end
    end

    assign PADDR   = paddr_q;
    assign PWRITE  = pwrite_q;
    assign PWDATA  = pwdata_q;
    assign PSTRB   = pstrb_q;
    assign PSEL    = psel_q;
    assign PENABLE = penable_q;
    assign BVALID  = bvalid_q;
    assign BRESP   = bresp_q;
    assign RVALID  = rvalid_q;
    assign RRESP   = rresp_q;
    assign RDATA   = rdata_q;

endmodule
`default_nettype wire
